sram_responder: RTL

Clocked, synthesizable model of the external 16-bit SRAM chip: the responder end of the SRAM bus that the MEM-stage cache controller drives. It decodes the active-low chip, output, write and byte-lane strobes, stores writes with per-byte masking, and drives read data onto the bidirectional data bus after a programmable latency. It replaces the physical chip in simulation and FPGA loopback builds, and exposes access counters and a bus-conflict flag for verification.

---
 rtl/sram_resp_pkg.sv | 16 +
 rtl/sram_byte_bank.sv | 28 ++
 rtl/sram_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// Shared constants for the SRAM responder: bus/lane widths, latency limit, FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sram_resp_pkg;

  localparam int DQ_W         = 16;
  localparam int LANE_W       = 8;
  localparam int MAX_READ_LAT = 7;

  // Read FSM encodings, kept as plain constants so older tools can consume them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_READ_WAIT = 2'd1;
  localparam state_t ST_DRIVE     = 2'd2;

endpackage

// File: rtl/sram_byte_bank.sv
// One byte lane of SRAM storage: 8 bits x 2^DEPTH_LOG2, write-enabled, asynchronous read.
// Latency: write lands at the clock edge; read data follows addr combinationally.
// Backpressure: none, every write enable is accepted.
// Ports: clk, we (write this lane), addr (word index), wdat (lane data in), rdat (lane data out).
module sram_byte_bank
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [LANE_W-1:0]     wdat,
  output logic [LANE_W-1:0]     rdat
);

  // Storage is deliberately not reset: a real SRAM powers up with arbitrary contents.
  logic [LANE_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdat;
    end
  end

  assign rdat = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Behavioural SRAM chip: decodes active-low strobes, masked byte writes, reads driven after READ_LAT edges.
// Latency: write visible to the next sampled read; read data on DQ after READ_LAT same-address read edges.
// Backpressure: none; the bus master owns all timing and the responder never stalls it.
// Ports: clk/rst (async active-low), SRAM_* chip pins (DQ bidirectional), rd_cnt/wr_cnt access counters,
//        conflict (sticky, set when a write and output-enable are sampled together).
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 2   // legal range 1..MAX_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic              conflict
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  // Per-edge decode. A write wins over an output enable sampled in the same cycle.
  logic samp_wr, samp_rd, samp_conf;
  assign samp_wr   = !SRAM_CE_N && !SRAM_WE_N;
  assign samp_rd   = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
  assign samp_conf = samp_wr && !SRAM_OE_N;

  state_t              state_q,    state_d;
  logic [2:0]          lat_cnt_q,  lat_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
  logic [DQ_W-1:0]     dout_q,     dout_d;
  logic                prev_wr_q,  prev_wr_d;
  logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
  logic [15:0]         rd_cnt_q,   rd_cnt_d;
  logic [15:0]         wr_cnt_q,   wr_cnt_d;
  logic                conflict_q, conflict_d;

  logic [DQ_W-1:0]     mem_rdat;

  // Storage: one bank per byte lane, indexed by the low address bits (upper bits alias).
  sram_byte_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank_hi (
    .clk  (clk),
    .we   (samp_wr && !SRAM_UB_N),
    .addr (SRAM_ADDR[DEPTH_LOG2-1:0]),
    .wdat (SRAM_DQ[DQ_W-1:LANE_W]),
    .rdat (mem_rdat[DQ_W-1:LANE_W])
  );

  sram_byte_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank_lo (
    .clk  (clk),
    .we   (samp_wr && !SRAM_LB_N),
    .addr (SRAM_ADDR[DEPTH_LOG2-1:0]),
    .wdat (SRAM_DQ[LANE_W-1:0]),
    .rdat (mem_rdat[LANE_W-1:0])
  );

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    wr_addr_d  = wr_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    conflict_d = conflict_q;
    prev_wr_d  = samp_wr;

    if (samp_wr) begin
      state_d   = ST_IDLE;
      wr_addr_d = SRAM_ADDR;
      // A held write is one burst: count only its first edge, or when the address moves.
      if (!prev_wr_q || (SRAM_ADDR != wr_addr_q)) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end
      if (samp_conf) begin
        conflict_d = 1'b1;
      end
    end else if (samp_rd) begin
      if ((state_q == ST_IDLE) || (SRAM_ADDR != rd_addr_q)) begin
        // New read (or the address moved): the full latency starts over.
        rd_addr_d = SRAM_ADDR;
        lat_cnt_d = LAT_INIT;
        if (READ_LAT == 1) begin
          state_d  = ST_DRIVE;
          dout_d   = mem_rdat;
          rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end else if (state_q == ST_READ_WAIT) begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          state_d  = ST_DRIVE;
          dout_d   = mem_rdat;
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end else begin
        // Holding in DRIVE: keep tracking the array so the bus shows current contents.
        dout_d = mem_rdat;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      prev_wr_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      prev_wr_q  <= prev_wr_d;
      wr_addr_q  <= wr_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  // Drive only while in DRIVE and the pins still request a read; state_q is reset
  // asynchronously, so the bus releases the moment rst falls.
  logic drive_ok;
  assign drive_ok = (state_q == ST_DRIVE) && samp_rd;

  assign SRAM_DQ[DQ_W-1:LANE_W] = (drive_ok && !SRAM_UB_N) ? dout_q[DQ_W-1:LANE_W] : {LANE_W{1'bz}};
  assign SRAM_DQ[LANE_W-1:0]    = (drive_ok && !SRAM_LB_N) ? dout_q[LANE_W-1:0]    : {LANE_W{1'bz}};

  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;
  assign conflict = conflict_q;

endmodule
